restore_stream: RTL and testbench
=================================

// Module: restore_stream
// PURPOSE
//  Parametrised haze-removal restore stage: J = (I - A) * (1/t) + A per channel,
//  saturated to [0, 2^DW-1]. Generalises the fixed 3x8-bit restore with ready/valid
//  backpressure, channel/width parameters, optional rounding, a 1/t ceiling (t0 floor),
//  per-frame latching of A, bypass mode and a per-frame clipped-pixel counter.
//  Sits between the transmission-estimate stage and the output video sink.
// PARAMETERS
//  DW         8        bits per channel (unsigned pixel and A)
//  NCH        3        channels per pixel, packed ch0 in LSBs
//  IT_W       12       inv_t width, unsigned Q(IT_W-FRAC).FRAC
//  FRAC       8        fractional bits of inv_t (1 <= FRAC < IT_W)
//  ROUND      0        0: floor (arithmetic shift); 1: add 2^(FRAC-1) before shift
//  INV_T_MAX  12'hA00  inv_t ceiling, in inv_t units (default 10.0 -> t0 = 0.1)
//  CNT_W      24       clip counter width
// PORTS
//  clk            in   1           clock, all logic on rising edge
//  rst_n          in   1           async active-low reset
//  in_pix         in   NCH*DW      hazy pixel I
//  in_a           in   NCH*DW      atmospheric light A (sampled only on SOF beat)
//  in_inv_t       in   IT_W        1/t for this pixel
//  in_sof         in   1           first pixel of frame
//  in_valid       in   1           input beat valid
//  in_ready       out  1           input beat accepted when in_valid & in_ready
//  cfg_bypass     in   1           1: out_pix = in_pix, same latency
//  out_pix        out  NCH*DW      restored pixel J
//  out_sof        out  1           SOF aligned with out_pix
//  out_valid      out  1           output beat valid
//  out_ready      in   1           sink ready
//  clip_cnt_last  out  CNT_W       pixels with >=1 clamped channel in previous frame
// BEHAVIOUR
//  - Reset: out_pix=0, out_sof=0, out_valid=0, clip_cnt_last=0, A register=0,
//    running clip count=0, all stage valids=0. in_ready=1 out of reset.
//  - 3-stage pipeline (S1 subtract/ceiling, S2 multiply, S3 shift/add/clamp), latency
//    3 cycles from accepted beat to out_valid when out_ready held high.
//  - Global enable en = !out_valid | out_ready; in_ready = en. When en=0 all stages
//    hold; no beat dropped or duplicated. out_pix/out_sof stable while out_valid & !out_ready.
//  - Bubbles propagate as valid=0 stages; throughput 1 pixel/cycle when unstalled.
//  - A latching: accepted beat with in_sof=1 loads A_reg <= in_a and that pixel uses
//    in_a; other beats use A_reg. in_a ignored otherwise. in_sof without prior SOF after
//    reset: pixels use A_reg=0.
//  - inv_t_eff = min(in_inv_t, INV_T_MAX), sampled in S1 with the pixel.
//  - diff = {0,I} - {0,A}, signed DW+1 bits; prod = diff * {0,inv_t_eff}, signed
//    DW+IT_W+2 bits; term = (prod + (ROUND ? 2^(FRAC-1) : 0)) >>> FRAC (arithmetic);
//    sum = term + A, signed wide enough for no overflow; J = sum<0 ? 0 :
//    sum>2^DW-1 ? 2^DW-1 : sum. Per channel, independent.
//  - Bypass: cfg_bypass sampled in S1 per beat; bypassed beats output I unchanged and
//    never count as clipped. Toggling mid-stream affects only beats accepted after.
//  - Clip counter counts output transfers (out_valid & out_ready). On a transfer with
//    out_sof=1: clip_cnt_last <= running count, running <= (this pixel clipped ? 1 : 0).
//    Otherwise running += clipped. Running saturates at 2^CNT_W-1.
//  - Async reset mid-frame clears pipeline; in-flight beats are lost, no output.
// TESTING (defaults; A=100 all channels unless noted)
//  1 I=200, inv_t=0x200 (2.0) -> 300 clamps, J=255, clip_cnt counts 1; I=50,
//    inv_t=0x180 -> J=25; out_valid exactly 3 cycles after accept.
//  2 Rounding: I=101, inv_t=0x180 -> ROUND=0 J=101, ROUND=1 J=102; I=99 -> ROUND=0 J=98,
//    ROUND=1 J=99.
//  3 Ceiling: I=110, inv_t=0xFFF -> uses 0xA00 (10.0) -> J=200; inv_t=0x100 -> J=110.
//  4 Backpressure: stream 8 beats, out_ready low cycles 2-5 -> in_ready low, output
//    order/values identical to unstalled run, out_pix stable while stalled.
//  5 A latching: frame1 SOF A=100, change in_a=50 mid-frame -> mid-frame pixels still
//    use 100; frame2 SOF with A=50 -> uses 50 from SOF pixel; clip_cnt_last updates on
//    frame2 out_sof transfer to frame1 clip count.
//  6 Bypass on, I=200 inv_t=0x200 -> J=200, no clip; reset asserted mid-stream ->
//    out_valid=0 next edge, no stale beats after release.

Source files
------------

// File: rtl/restore_stream.sv
// Haze-removal restore stage: J = (I - A) * inv_t + A per channel, saturated to the pixel range.
// Three-stage ready/valid pipeline with per-frame A latching, bypass and a clipped-pixel counter.
module restore_stream #(
    parameter int              DW        = 8,
    parameter int              NCH       = 3,
    parameter int              IT_W      = 12,
    parameter int              FRAC      = 8,
    parameter int              ROUND     = 0,
    parameter logic [IT_W-1:0] INV_T_MAX = 12'hA00,
    parameter int              CNT_W     = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH*DW-1:0]   in_pix,
    input  logic [NCH*DW-1:0]   in_a,
    input  logic [IT_W-1:0]     in_inv_t,
    input  logic                in_sof,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                cfg_bypass,
    output logic [NCH*DW-1:0]   out_pix,
    output logic                out_sof,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    clip_cnt_last
);

    localparam int PW    = DW + IT_W + 2;
    localparam int SW    = PW + 1;
    localparam int RND_I = (ROUND != 0) ? (1 << (FRAC - 1)) : 0;

    // Handshake: a beat moves on a rising edge when valid & ready are both high.
    // The whole pipeline advances together whenever the output register can be refilled.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic [NCH*DW-1:0] a_reg;
    logic [NCH*DW-1:0] a_use;
    logic [IT_W-1:0]   inv_eff;
    logic signed [DW:0] d_c [NCH];

    logic               s1_valid, s1_sof, s1_byp;
    logic [NCH*DW-1:0]  s1_pix, s1_a;
    logic [IT_W-1:0]    s1_inv;
    logic signed [DW:0] s1_diff [NCH];

    logic signed [PW-1:0] p_c [NCH];
    logic                 s2_valid, s2_sof, s2_byp;
    logic [NCH*DW-1:0]    s2_pix, s2_a;
    logic signed [PW-1:0] s2_prod [NCH];

    logic signed [PW-1:0] term_c [NCH];
    logic signed [SW-1:0] sum_c  [NCH];
    logic [NCH*DW-1:0]    j_c;
    logic                 clip_c;

    logic                 out_clip;
    logic [CNT_W-1:0]     running;

    // S1: pick A (fresh on SOF), cap inv_t, form signed differences
    always_comb begin
        a_use   = in_sof ? in_a : a_reg;
        inv_eff = (in_inv_t > INV_T_MAX) ? INV_T_MAX : in_inv_t;
        for (int ch = 0; ch < NCH; ch++) begin
            d_c[ch] = $signed({1'b0, in_pix[ch*DW +: DW]}) - $signed({1'b0, a_use[ch*DW +: DW]});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_byp   <= 1'b0;
            s1_pix   <= '0;
            s1_a     <= '0;
            s1_inv   <= '0;
            for (int ch = 0; ch < NCH; ch++) s1_diff[ch] <= '0;
        end else if (en) begin
            if (in_valid && in_sof) a_reg <= in_a;
            s1_valid <= in_valid;
            s1_sof   <= in_sof;
            s1_byp   <= cfg_bypass;
            s1_pix   <= in_pix;
            s1_a     <= a_use;
            s1_inv   <= inv_eff;
            for (int ch = 0; ch < NCH; ch++) s1_diff[ch] <= d_c[ch];
        end
    end

    // S2: signed difference times non-negative inv_t
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            p_c[ch] = PW'(s1_diff[ch]) * PW'($signed({1'b0, s1_inv}));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_byp   <= 1'b0;
            s2_pix   <= '0;
            s2_a     <= '0;
            for (int ch = 0; ch < NCH; ch++) s2_prod[ch] <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_byp   <= s1_byp;
            s2_pix   <= s1_pix;
            s2_a     <= s1_a;
            for (int ch = 0; ch < NCH; ch++) s2_prod[ch] <= p_c[ch];
        end
    end

    // S3: scale back, add A, clamp; a channel hitting either rail marks the pixel clipped
    always_comb begin
        j_c    = '0;
        clip_c = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            term_c[ch] = (s2_prod[ch] + PW'(RND_I)) >>> FRAC;
            sum_c[ch]  = SW'(term_c[ch]) + SW'($signed({1'b0, s2_a[ch*DW +: DW]}));
            if (sum_c[ch][SW-1]) begin
                j_c[ch*DW +: DW] = '0;
                clip_c           = 1'b1;
            end else if (|sum_c[ch][SW-2:DW]) begin
                j_c[ch*DW +: DW] = '1;
                clip_c           = 1'b1;
            end else begin
                j_c[ch*DW +: DW] = sum_c[ch][DW-1:0];
            end
        end
        if (s2_byp) begin
            j_c    = s2_pix;
            clip_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_pix   <= '0;
            out_clip  <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            out_sof   <= s2_sof;
            out_pix   <= j_c;
            out_clip  <= clip_c;
        end
    end

    // Counter follows delivered beats only, so stalls never double-count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running       <= '0;
            clip_cnt_last <= '0;
        end else if (out_valid && out_ready) begin
            if (out_sof) begin
                clip_cnt_last <= running;
                running       <= CNT_W'(out_clip);
            end else if (out_clip && (running != '1)) begin
                running <= running + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_restore_stream.sv
// Directed bench for restore_stream: floor and rounding instances share one stimulus stream.
module tb_restore_stream;

  logic        clk;
  logic        rst_n;
  logic [23:0] in_pix;
  logic [23:0] in_a;
  logic [11:0] in_inv_t;
  logic        in_sof;
  logic        in_valid;
  logic        cfg_bypass;
  logic        out_ready;

  logic        in_ready0, in_ready1;
  logic [23:0] out_pix0, out_pix1;
  logic        out_sof0, out_sof1;
  logic        out_valid0, out_valid1;
  logic [23:0] clip0, clip1;

  int checks = 0;
  int errors = 0;

  restore_stream #(.ROUND(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_pix(in_pix), .in_a(in_a), .in_inv_t(in_inv_t),
    .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready0), .cfg_bypass(cfg_bypass),
    .out_pix(out_pix0), .out_sof(out_sof0), .out_valid(out_valid0), .out_ready(out_ready),
    .clip_cnt_last(clip0)
  );

  restore_stream #(.ROUND(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_pix(in_pix), .in_a(in_a), .in_inv_t(in_inv_t),
    .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready1), .cfg_bypass(cfg_bypass),
    .out_pix(out_pix1), .out_sof(out_sof1), .out_valid(out_valid1), .out_ready(out_ready),
    .clip_cnt_last(clip1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [23:0] pix;
    logic [23:0] a;
    logic [11:0] inv;
    logic        sof;
    logic        byp;
    logic [23:0] e0;
    logic [23:0] e1;
    logic [23:0] cl;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input int i);
    in_pix     = vecs[i].pix;
    in_a       = vecs[i].a;
    in_inv_t   = vecs[i].inv;
    in_sof     = vecs[i].sof;
    cfg_bypass = vecs[i].byp;
    in_valid   = 1'b1;
  endtask

  // scoreboard: {sof, clip_cnt_last after transfer, round=1 pixel, round=0 pixel}
  logic [72:0] exp_q[$];
  logic        cl_pend = 1'b0;
  logic [23:0] cl_exp  = '0;
  logic        stall_prev = 1'b0;
  logic [23:0] held_pix = '0;

  task automatic push(input int i);
    exp_q.push_back({vecs[i].sof, vecs[i].cl, vecs[i].e1, vecs[i].e0});
  endtask

  initial begin
    logic [72:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cl_pend    = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (cl_pend) begin
          chk("clip_cnt_last_r0", clip0, cl_exp);
          chk("clip_cnt_last_r1", clip1, cl_exp);
          cl_pend = 1'b0;
        end
        if (out_valid0 && !out_ready) begin
          chk("in_ready_stall", in_ready0, 0);
          if (stall_prev) chk("out_pix_stable", out_pix0, held_pix);
          held_pix   = out_pix0;
          stall_prev = 1'b1;
        end else begin
          stall_prev = 1'b0;
        end
        if (out_valid0 && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", out_pix0, 0);
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got out_valid=1 required out_valid=0");
          end else begin
            e = exp_q.pop_front();
            chk("out_pix_r0", out_pix0, e[23:0]);
            chk("out_pix_r1", out_pix1, e[47:24]);
            chk("out_sof", out_sof0, e[72]);
            chk("out_valid_r1", out_valid1, 1);
            cl_exp  = e[71:48];
            cl_pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int  cyc;
    int  guard;
    logic acc;
    logic saw;

    // A = 100 unless noted; pixels packed {ch2, ch1, ch0}
    vecs[0]  = '{pix:24'h6432C8, a:24'h646464, inv:12'h200, sof:1'b1, byp:1'b0, e0:24'h6400FF, e1:24'h6400FF, cl:24'd0};
    vecs[1]  = '{pix:24'h636532, a:24'h000000, inv:12'h180, sof:1'b0, byp:1'b0, e0:24'h626519, e1:24'h636619, cl:24'd0};
    vecs[2]  = '{pix:24'h6E6E6E, a:24'h000000, inv:12'hFFF, sof:1'b0, byp:1'b0, e0:24'hC8C8C8, e1:24'hC8C8C8, cl:24'd0};
    vecs[3]  = '{pix:24'hFF006E, a:24'h000000, inv:12'h100, sof:1'b0, byp:1'b0, e0:24'hFF006E, e1:24'hFF006E, cl:24'd0};
    vecs[4]  = '{pix:24'h78FF00, a:24'h000000, inv:12'hA00, sof:1'b0, byp:1'b0, e0:24'hFFFF00, e1:24'hFFFF00, cl:24'd0};
    vecs[5]  = '{pix:24'hC8C8C8, a:24'h000000, inv:12'h200, sof:1'b0, byp:1'b1, e0:24'hC8C8C8, e1:24'hC8C8C8, cl:24'd0};
    vecs[6]  = '{pix:24'h07FF00, a:24'h323232, inv:12'h000, sof:1'b0, byp:1'b0, e0:24'h646464, e1:24'h646464, cl:24'd0};
    vecs[7]  = '{pix:24'h030201, a:24'h323232, inv:12'h001, sof:1'b0, byp:1'b0, e0:24'h636363, e1:24'h646464, cl:24'd0};
    vecs[8]  = '{pix:24'h32283C, a:24'h323232, inv:12'h200, sof:1'b1, byp:1'b0, e0:24'h321E46, e1:24'h321E46, cl:24'd2};
    vecs[9]  = '{pix:24'h3200FF, a:24'h000000, inv:12'h200, sof:1'b0, byp:1'b0, e0:24'h3200FF, e1:24'h3200FF, cl:24'd2};
    vecs[10] = '{pix:24'h646464, a:24'h646464, inv:12'h100, sof:1'b1, byp:1'b0, e0:24'h646464, e1:24'h646464, cl:24'd1};

    rst_n = 1'b0;
    in_pix = '0; in_a = '0; in_inv_t = '0; in_sof = 1'b0; in_valid = 1'b0;
    cfg_bypass = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid0, 0);
    chk("reset_out_pix", out_pix0, 0);
    chk("reset_out_sof", out_sof0, 0);
    chk("reset_clip_cnt", clip0, 0);
    chk("reset_in_ready", in_ready0, 1);
    chk("reset_out_valid_r1", out_valid1, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // first-beat latency
    drive(0);
    push(0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("latency_edge1", out_valid0, 0);
    @(posedge clk); #1;
    chk("latency_edge2", out_valid0, 0);
    @(posedge clk); #1;
    chk("latency_edge3", out_valid0, 1);

    // stream with out_ready low for stream cycles 2..5
    cyc = 0;
    for (int i = 1; i < 11; i++) begin
      drive(i);
      push(i);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 20) begin
        out_ready = !(cyc >= 2 && cyc <= 5);
        cyc++;
        @(negedge clk);
        acc = in_ready0;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || cl_pend) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("final_clip_cnt", clip0, 1);

    // reset mid-stream with a full stalled pipeline
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_reset_valid", out_valid0, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", out_valid0, 0);
    chk("async_reset_pix", out_pix0, 0);
    chk("async_reset_clip", clip0, 0);
    @(posedge clk); #1;
    chk("reset_edge_valid", out_valid0, 0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      saw = saw | out_valid0 | out_valid1;
    end
    chk("no_stale_beats", saw, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
